z80_bus_master: RTL
===================

// Module: z80_bus_master
//
// PURPOSE
// - CPU-side initiator for the Z80 external memory bus; the counterpart of the memory responder.
// - Turns one core request (read, write or M1 opcode fetch) into a T1/T2/T3 machine cycle.
// - Drives addr_bus, data_bus (writes only), MREQ_L, RD_L, WR_L and M1_L.
// - Returns read data and a one-cycle done pulse to the core.
// - The memory responder registers its data on the clock edge where it sees RD_L low.
// - The memory responder commits a write one edge after it sees WR_L low.
// - Strobes are therefore held through T3 so both cases fit inside one cycle.
//
// PARAMETERS
// - AW        16  address width; addr and addr_bus.
// - DW        8   data width; wdata, rdata and data_bus.
// - MAX_WAIT  15  wait-state timeout in cycles. Used only with Z80_WAIT_EN.
//
// PORTS
// - clk       in     1   system clock; all logic on the posedge.
// - rst       in     1   synchronous, active-high reset.
// - req       in     1   core request; sampled only when ready=1.
// - we        in     1   1 = write, 0 = read; latched with req.
// - m1        in     1   opcode fetch (asserts M1_L); ignored when we=1.
// - addr      in     AW  request address; latched with req.
// - wdata     in     DW  write data; latched with req.
// - ready     out    1   1 only in IDLE; the block accepts req.
// - done      out    1   one-cycle pulse when the bus cycle completes.
// - rdata     out    DW  read data; valid when done=1, held until the next done.
// - err       out    1   one-cycle pulse on wait timeout (Z80_WAIT_EN only).
// - MREQ_L    out    1   memory request strobe, active low.
// - RD_L      out    1   read strobe, active low.
// - WR_L      out    1   write strobe, active low.
// - M1_L      out    1   opcode-fetch marker, active low.
// - WAIT_L    in     1   responder wait request, active low.
// - addr_bus  inout  AW  driven T1..T3; Z otherwise.
// - data_bus  inout  DW  driven T1..T3 of writes only; Z otherwise.
//
// BEHAVIOUR
// - Reset values: ready=1; done=0; err=0; rdata=0.
// - Reset values: MREQ_L=RD_L=WR_L=M1_L=1; addr_bus and data_bus = Z.
// - All outputs are registered; no combinational path from req to the bus.
// - States and transitions:
//   - IDLE -> T1 on req (latch we, m1&~we, addr, wdata).
//   - T1 -> T2; T2 -> T3 (or TW, see CONFIGURATION).
//   - T3 -> DONE; DONE -> IDLE.
// - Cycle n is the cycle req is accepted.
// - T1 (n+1): addr_bus driven; M1_L=0 if fetch.
// - T1 (n+1), write only: data_bus driven with wdata.
// - T2 (n+2): MREQ_L=0; RD_L=0 for reads, WR_L=0 for writes.
// - T3 (n+3): all strobes and bus drives held.
// - Read sampling: rdata <= data_bus on the edge ending T3.
// - DONE (n+4): done=1; all strobes =1; both buses Z.
// - Next request accepted at n+5 at the earliest.
// - Minimum latency is 4 cycles from acceptance to done.
// - DONE is the bus-turnaround cycle: the responder releases data_bus there after a read.
// - The master never drives data_bus in the cycle after RD_L rises.
// - req is ignored outside IDLE; there is no queueing.
// - Back-to-back requests occupy 5 cycles each.
// - data_bus is never driven while RD_L=0. WR_L and RD_L are never low together.
// - Reset during any state: the next edge forces IDLE and reset values.
//   - In-flight request is dropped; no done; rdata unchanged from reset value.
//
// CONFIGURATION
// - Macro Z80_WAIT_EN defined:
//   - WAIT_L is sampled on the edge ending T2; if 0, go to TW instead of T3.
//   - TW holds all strobes and drives; stay while WAIT_L=0, then go to T3.
//   - A 4-bit counter counts cycles spent in TW.
//   - At MAX_WAIT cycles in TW: go to DONE with err=1, done=1 and rdata unchanged.
// - Macro Z80_WAIT_EN undefined:
//   - WAIT_L is ignored; TW is unreachable; err is tied 0; the counter is not built.
//
// TESTING
// - Read 0x0002 (memory holds 0x00), then read 0x0001 (0xBB):
//   -> RD_L low for 2 cycles; done at n+4; rdata=0x00, then 0xBB.
// - Write 0x5A to 0x0010, then read 0x0010:
//   -> WR_L low 2 cycles with data_bus=0x5A; read returns rdata=0x5A.
// - Fetch, req+m1=1 at 0x0000 (holds 0x2A):
//   -> M1_L=0 during T1..T3; rdata=0x2A.
// - req held high for 20 cycles:
//   -> exactly 4 done pulses; ready low 4 of every 5 cycles; no strobe overlap.
// - rst=1 during T2 of a write:
//   -> next edge: WR_L=MREQ_L=1, buses Z, ready=1, no done.
// - Z80_WAIT_EN, WAIT_L=0 for 3 cycles from T2:
//   -> 3 TW cycles, done at n+7, err=0.
// - Z80_WAIT_EN, WAIT_L stuck at 0:
//   -> err=done=1 after 15 TW cycles.

Source files
------------

// File: rtl/z80_bus_master.sv
// Z80 memory-bus initiator: turns one core request into a T1/T2/T3 machine cycle.
// Optional wait-state support with timeout is enabled by defining Z80_WAIT_EN.
module z80_bus_master #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          m1,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          MREQ_L,
    output logic          RD_L,
    output logic          WR_L,
    output logic          M1_L,
    input  logic          WAIT_L,
    inout  wire  [AW-1:0] addr_bus,
    inout  wire  [DW-1:0] data_bus
);

    // state  | meaning
    // IDLE   | ready for a request
    // T1     | address (and write data) driven, M1_L for fetch
    // T2     | MREQ_L and RD_L/WR_L asserted
    // TW     | wait state, everything held (Z80_WAIT_EN only)
    // T3     | everything held; read data captured at its end
    // DONE   | done pulse, strobes released, bus turnaround
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TW, S_T3, S_DONE
    } state_t;

    state_t state, next_state;

    logic          accept;
    logic          we_q, fetch_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          addr_oe, data_oe;
    logic          wait_req;

    logic          we_n, fetch_n, drive_n, strobe_n;
    logic          ready_d, done_d, mreq_d, rd_d, wr_d, m1_d, addr_oe_d, data_oe_d;
    logic          err_d;

    assign accept = (state == S_IDLE) && req;

`ifdef Z80_WAIT_EN
    logic [3:0] wait_cnt;
    logic       err_q;

    assign wait_req = ~WAIT_L;
    assign err      = err_q;

    // Down-counter loaded on the edge ending T2; terminal count marks the last TW cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == S_T2) begin
            wait_cnt <= 4'(MAX_WAIT - 1);
        end else if (state == S_TW && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_wait;

    assign wait_req    = 1'b0;
    assign err         = 1'b0;
    assign unused_wait = WAIT_L | (MAX_WAIT == 0) | err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = S_T1;
            S_T1:   next_state = S_T2;
            S_T2:   next_state = wait_req ? S_TW : S_T3;
            S_TW: begin
`ifdef Z80_WAIT_EN
                if (!wait_req)                next_state = S_T3;
                else if (wait_cnt == 4'd0)    next_state = S_DONE;
                else                          next_state = S_TW;
`else
                next_state = S_IDLE;
`endif
            end
            S_T3:   next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so the request
    // attributes being latched this edge must be used directly when accepting.
    always_comb begin
        we_n      = accept ? we : we_q;
        fetch_n   = accept ? (m1 & ~we) : fetch_q;
        drive_n   = next_state inside {S_T1, S_T2, S_TW, S_T3};
        strobe_n  = next_state inside {S_T2, S_TW, S_T3};
        ready_d   = (next_state == S_IDLE);
        done_d    = (next_state == S_DONE);
        err_d     = (state == S_TW) && (next_state == S_DONE);
        mreq_d    = ~strobe_n;
        rd_d      = ~(strobe_n & ~we_n);
        wr_d      = ~(strobe_n & we_n);
        m1_d      = ~(drive_n & fetch_n);
        addr_oe_d = drive_n;
        data_oe_d = drive_n & we_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            fetch_q <= m1 & ~we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b1;
            done    <= 1'b0;
            MREQ_L  <= 1'b1;
            RD_L    <= 1'b1;
            WR_L    <= 1'b1;
            M1_L    <= 1'b1;
            addr_oe <= 1'b0;
            data_oe <= 1'b0;
            rdata   <= '0;
        end else begin
            ready   <= ready_d;
            done    <= done_d;
            MREQ_L  <= mreq_d;
            RD_L    <= rd_d;
            WR_L    <= wr_d;
            M1_L    <= m1_d;
            addr_oe <= addr_oe_d;
            data_oe <= data_oe_d;
            if (state == S_T3 && !we_q) begin
                rdata <= data_bus;
            end
        end
    end

    assign addr_bus = addr_oe ? addr_q  : 'z;
    assign data_bus = data_oe ? wdata_q : 'z;

endmodule
